// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, exception codes and the fetch-entry record.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch-address legality check: flags misaligned or out-of-window PCs as AdEL.
module fetch_addr_check
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_lo,
    input  logic [31:0] pc_hi,
    output logic [4:0]  exc
);

    always_comb begin
        exc = EXC_NONE;
        if ((pc[1:0] != 2'b00) || (pc < pc_lo) || (pc > pc_hi)) begin
            exc = EXC_ADEL;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode; FWFT head, flush on redirect.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] PC_LO = 32'h0000_3000,
    parameter logic [31:0] PC_HI = 32'h0000_4FFC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_valid,
    input  logic [31:0]              f_pc,
    input  logic [31:0]              f_instr,
    output logic                     f_ready,
    input  logic                     flush,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [31:0]              d_pc,
    output logic [31:0]              d_instr,
    output logic [4:0]               d_exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  entry_in;
    fetch_entry_t  head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [4:0]    f_exc;
    logic          push;
    logic          pop;

    fetch_addr_check u_addr_check (
        .pc    (f_pc),
        .pc_lo (PC_LO),
        .pc_hi (PC_HI),
        .exc   (f_exc)
    );

    // f_ready depends only on stored occupancy, never on d_ready
    assign f_ready = (count_q != CNT_FULL);
    assign d_valid = (count_q != '0);
    assign push    = f_valid & f_ready & ~flush;
    assign pop     = d_valid & d_ready & ~flush;
    assign count   = count_q;

    always_comb begin
        entry_in.pc    = f_pc;
        entry_in.exc   = f_exc;
        entry_in.instr = (f_exc == EXC_NONE) ? f_instr : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; d_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_in;
    end

    assign head    = mem[rd_ptr];
    assign d_pc    = d_valid ? head.pc    : 32'h0;
    assign d_instr = d_valid ? head.instr : 32'h0;
    assign d_exc   = d_valid ? head.exc   : 5'd0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus randomized bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] PC_LO = 32'h0000_3000;
    localparam logic [31:0] PC_HI = 32'h0000_4FFC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } ref_entry_t;

    logic        clk = 0;
    logic        reset = 0;
    logic        f_valid = 0;
    logic [31:0] f_pc = '0;
    logic [31:0] f_instr = '0;
    logic        f_ready;
    logic        flush = 0;
    logic        d_valid;
    logic        d_ready = 0;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;
    ref_entry_t model_q[$];

    fetch_buffer #(.DEPTH(DEPTH), .PC_LO(PC_LO), .PC_HI(PC_HI)) dut (
        .clk     (clk),
        .reset   (reset),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_ready (f_ready),
        .flush   (flush),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_exc   (d_exc),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ":count"},   64'(count),   64'(n));
        chk({tag, ":d_valid"}, 64'(d_valid), 64'(n != 0));
        chk({tag, ":f_ready"}, 64'(f_ready), 64'(n != DEPTH));
        chk({tag, ":d_pc"},    64'(d_pc),    (n != 0) ? 64'(model_q[0].pc)    : 64'd0);
        chk({tag, ":d_instr"}, 64'(d_instr), (n != 0) ? 64'(model_q[0].instr) : 64'd0);
        chk({tag, ":d_exc"},   64'(d_exc),   (n != 0) ? 64'(model_q[0].exc)   : 64'd0);
    endtask

    // Called just after a falling edge: drive inputs, cross one rising edge, then check.
    task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                        input logic [31:0] instr, input logic dr, input logic fl);
        bit do_push, do_pop, legal;
        ref_entry_t e;
        f_valid = fv; f_pc = pc; f_instr = instr; d_ready = dr; flush = fl;
        do_push = fv && (model_q.size() < DEPTH) && !fl;
        do_pop  = dr && (model_q.size() > 0) && !fl;
        legal   = (pc % 4 == 0) && (pc >= PC_LO) && (pc <= PC_HI);
        e.pc    = pc;
        e.exc   = legal ? 5'd0 : 5'd4;
        e.instr = legal ? instr : 32'h0;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] rpc;
        // Reset held for two cycles
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        check_model("reset");
        reset = 1;
        idle("idle0");
        idle("idle1");

        // Fill to full, then a fifth offer must be refused
        for (int i = 0; i < 4; i++)
            step("fill", 1'b1, 32'h3000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        chk("full:d_pc", 64'(d_pc), 64'h3000);
        step("fifth", 1'b1, 32'h3010, $urandom, 1'b0, 1'b0);
        chk("fifth:count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming across pointer wrap
        pc = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            step("stream", 1'b1, pc, $urandom, 1'b1, 1'b0);
            chk("stream:count1", 64'(count), 64'd1);
            chk("stream:pc", 64'(d_pc), 64'(pc));
            pc += 4;
        end
        step("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Address errors and one legal word
        step("adel_misalign", 1'b1, 32'h3002, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step("adel_low",      1'b1, 32'h2FFC, 32'hCAFE_F00D, 1'b0, 1'b0);
        step("adel_high",     1'b1, 32'h5000, 32'h1234_5678, 1'b0, 1'b0);
        step("legal",         1'b1, 32'h3010, 32'h8765_4321, 1'b0, 1'b0);
        chk("adel:head_exc", 64'(d_exc), 64'd4);
        chk("adel:head_instr", 64'(d_instr), 64'd0);
        for (int i = 0; i < 4; i++)
            step("adel_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush at count=3 with push and pop also requested
        for (int i = 0; i < 3; i++)
            step("pre_flush", 1'b1, 32'h3100 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h3200, $urandom, 1'b1, 1'b1);
        chk("flush:count", 64'(count), 64'd0);
        step("post_flush", 1'b1, 32'h3400, 32'hA5A5_0001, 1'b0, 1'b0);
        chk("post_flush:d_pc", 64'(d_pc), 64'h3400);
        step("post_flush_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Async reset between edges with two entries held
        step("pre_rst", 1'b1, 32'h3500, $urandom, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 32'h3504, $urandom, 1'b0, 1'b0);
        f_valid = 0;
        #2;
        reset = 0;
        #1;
        model_q.delete();
        chk("async_rst:count", 64'(count), 64'd0);
        chk("async_rst:d_valid", 64'(d_valid), 64'd0);
        chk("async_rst:f_ready", 64'(f_ready), 64'd1);
        @(negedge clk);
        reset = 1;
        idle("after_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       rpc = 32'h3000 + ($urandom_range(0, 32'h7FF) * 4) + $urandom_range(1, 3);
                1:       rpc = 32'h2F00 + ($urandom_range(0, 63) * 4);
                2:       rpc = 32'h4F00 + ($urandom_range(0, 127) * 4);
                default: rpc = 32'h3000 + ($urandom_range(0, 32'h7FF) * 4);
            endcase
            step("rand", 1'($urandom_range(0, 3) != 0), rpc, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction prefetch queue between the fetch stage (PC register plus instruction memory) and decode. It accepts {PC, instruction} pairs whenever it has room, and its ready output drives the PC register's enable. It presents the oldest entry to decode through a valid/ready handshake, first-word-fall-through. It also tags address-error fetches and discards all contents on a branch/exception redirect.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
PC_LO, 32'h00003000, lowest legal fetch address (inclusive).
PC_HI, 32'h00004FFC, highest legal fetch address (inclusive).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
f_valid  input  1  fetch stage offers a word this cycle
f_pc  input  32  PC of offered word
f_instr  input  32  instruction word read at f_pc
f_ready  output  1  buffer accepts this cycle; also drives the PC register enable
flush  input  1  redirect: discard all entries
d_valid  output  1  head entry available to decode
d_ready  input  1  decode consumes head this cycle
d_pc  output  32  PC of head entry
d_instr  output  32  instruction of head entry
d_exc  output  5  exception code of head entry (0 = none, 4 = AdEL)
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular array of DEPTH entries {pc[31:0], instr[31:0], exc[4:0]}; rd_ptr and wr_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH. count holds 0..DEPTH.
- Reset (reset==0, async): rd_ptr=0, wr_ptr=0, count=0. Entry contents are not reset. Resulting outputs: d_valid=0, f_ready=1, d_pc=0, d_instr=0, d_exc=0.
- f_ready = (count != DEPTH). It is registered-state only, with no combinational path from d_ready. A pop while full does not allow a same-cycle push.
- push = f_valid & f_ready & ~flush. pop = d_valid & d_ready & ~flush.
- On push: entry[wr_ptr] <= {f_pc, f_instr, exc}, then wr_ptr++.
- exc = 4 if f_pc[1:0]!=0 or f_pc<PC_LO or f_pc>PC_HI, else 0. For a tagged entry, f_instr is stored as 32'h0.
- On pop: rd_ptr++.
- count updates: push only -> +1; pop only -> -1; push and pop together -> unchanged. Push and pop can coincide only when 0<count<DEPTH.
- Pops from an empty buffer and pushes to a full buffer cannot occur, because the gating above prevents them.
- d_valid = (count != 0). When d_valid=1, d_pc/d_instr/d_exc equal entry[rd_ptr]. When d_valid=0 these outputs are forced to 0.
- Latency: a word pushed at edge N is visible on d_* after edge N if the buffer was empty (one cycle of latency). There is no combinational f_* -> d_* bypass.
- flush is synchronous and has priority over everything. At the next edge rd_ptr=wr_ptr=0 and count=0. Any push or pop in the flush cycle is discarded. The cycle after a flush, f_ready=1 and d_valid=0.
- A reset assertion mid-operation takes effect immediately, regardless of flush, push or pop.
- The head is stable: while d_valid=1 and d_ready=0, d_* must not change.

Decomposition:
- Shared package cpu_pkg holds RESET_PC (32'h00003000), EXC_NONE (5'd0), EXC_ADEL (5'd4), and the fetch-entry struct {pc, instr, exc}.
- Address legality check is one small combinational sub-module, fetch_addr_check (inputs pc, PC_LO, PC_HI; output exc). The decode stage reuses it for jr targets.
- Pointers, count and storage stay in fetch_buffer.

Test Plan:
- Reset then idle, with reset low for 2 cycles: d_valid=0, f_ready=1, count=0, d_pc=0. After release, all of these hold with no stimulus.
- Fill: f_valid=1, d_ready=0, with PCs 0x3000, 0x3004, 0x3008, 0x300C on 4 edges. Then count=4, f_ready=0, d_pc=0x3000. A fifth offer (0x3010) is not accepted.
- Streaming: f_valid=1 and d_ready=1 continuously from empty. After the first edge count stays 1 and d_pc advances by 4 each cycle, starting at 0x3000. Run 10 cycles to cover pointer wrap.
- Address error: push f_pc=0x3002, then 0x2FFC, then 0x5000. Each pops with d_exc=4 and d_instr=0. Following push 0x3010 pops with d_exc=0.
- Flush with count=3, asserted with f_valid=1 and d_ready=1 in the same cycle: next cycle count=0, d_valid=0, f_ready=1. Then push 0x3400, which appears as d_pc=0x3400.
- Async reset mid-stream (count=2): reset falls between edges. count=0 and d_valid=0 immediately, without waiting for a clock edge.
